// File: rtl/ysyx_23060332_wbu.sv
// Write-back stage: retires one EXU instruction per handshake, extends load data, drives the RF write port.
// Optional IDU bypass outputs enabled by defining YSYX_23060332_WBU_FWD_EN.
module ysyx_23060332_wbu #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [DATA_W-1:0] exu_pc,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_result,
  input  logic              exu_wen,
  input  logic              exu_is_load,
  input  logic [2:0]        exu_funct3,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              reg_wen,
  output logic              commit_valid,
  output logic [DATA_W-1:0] commit_pc
`ifdef YSYX_23060332_WBU_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] pc_q;
  logic [ADDR_W-1:0] rd_q;
  logic [1:0]        off_q;
  logic              wen_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_data;

  // Byte lane selected by the latched address offset; halves ignore off[0].
  always_comb begin
    shifted   = mem_rdata >> {off_q, 3'b000};
    load_data = '0;
    case (funct3_q)
      3'd0: load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd4: load_data = {24'd0, shifted[7:0]};
      3'd1: load_data = off_q[1] ? {{16{mem_rdata[31]}}, mem_rdata[31:16]}
                                 : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd5: load_data = off_q[1] ? {16'd0, mem_rdata[31:16]} : {16'd0, mem_rdata[15:0]};
      3'd2: load_data = mem_rdata;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    exu_ready = (state == IDLE);
    case (state)
      IDLE:     if (exu_valid) state_nxt = exu_is_load ? WAIT_MEM : WRITE;
      WAIT_MEM: if (mem_rvalid) state_nxt = WRITE;
      WRITE:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Write-port outputs are loaded on the edge entering WRITE so they hold afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc_q         <= '0;
      rd_q         <= '0;
      off_q        <= '0;
      wen_q        <= 1'b0;
      funct3_q     <= '0;
      waddr        <= '0;
      wdata        <= '0;
      reg_wen      <= 1'b0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
    end else begin
      state        <= state_nxt;
      reg_wen      <= 1'b0;
      commit_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (exu_valid) begin
            pc_q     <= exu_pc;
            rd_q     <= exu_rd;
            off_q    <= exu_result[1:0];
            wen_q    <= exu_wen;
            funct3_q <= exu_funct3;
            if (!exu_is_load) begin
              waddr        <= exu_rd;
              wdata        <= exu_result;
              commit_pc    <= exu_pc;
              reg_wen      <= exu_wen & (|exu_rd);
              commit_valid <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            waddr        <= rd_q;
            wdata        <= load_data;
            commit_pc    <= pc_q;
            reg_wen      <= wen_q & (|rd_q);
            commit_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef YSYX_23060332_WBU_FWD_EN
  assign fwd_valid = reg_wen;
  assign fwd_addr  = waddr;
  assign fwd_data  = wdata;
`endif

endmodule
